// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing generator: default 640x480 geometry,
// pattern codes and the colour-bar palette.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PAT_WHITE   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BLACK   = 2'd3
  } pattern_t;

  localparam int DEF_H_TOTAL = 96 + 48 + 640 + 16;
  localparam int DEF_V_TOTAL = 2 + 33 + 480 + 10;

  function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
    return sync + bp + active + fp;
  endfunction

  // Left-to-right bar order; each channel is fully on or fully off.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Tick-enabled position counter for one display axis, laid out as
// sync, back porch, active, front porch, with window flags.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          sync_on,
  output logic          active,
  output logic [CW-1:0] pos
);

  localparam int            TOTAL   = axis_total(SYNC, BP, ACTIVE, FP);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);
  localparam logic [CW-1:0] S_END   = CW'(SYNC);
  localparam logic [CW-1:0] A_START = CW'(SYNC + BP);
  localparam logic [CW-1:0] A_END   = CW'(SYNC + BP + ACTIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= (count == LAST) ? '0 : count + 1'b1;
  end

  assign sync_on = (count < S_END);
  assign active  = (count >= A_START) && (count < A_END);
  assign pos     = active ? count - A_START : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator with a frame-synchronous test-pattern source.
// All outputs are registered on the pixel tick from the pre-increment counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit SYNC_POL = 1'b1,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    pattern_sel,
  output logic          HSync,
  output logic          VSync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic [7:0]    Red,
  output logic [7:0]    Green,
  output logic [7:0]    Blue
);

  localparam int            H_TOTAL  = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

  logic [DW-1:0] div;
  logic          tick;
  logic [CW-1:0] h_count, v_count, h_pos, v_pos;
  logic          h_sync, v_sync, h_active, v_active;
  logic          at_origin, vis;
  pattern_t      pat_q, pat_now;
  logic [CW-1:0] bar_cnt;
  logic [2:0]    bar_idx;
  logic [23:0]   rgb_next;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div <= '0;
    else
      div <= tick ? '0 : div + 1'b1;
  end

  vga_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(CW)) u_h (
    .clk     (clk),
    .rst     (rst),
    .en      (tick),
    .count   (h_count),
    .sync_on (h_sync),
    .active  (h_active),
    .pos     (h_pos)
  );

  vga_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(CW)) u_v (
    .clk     (clk),
    .rst     (rst),
    .en      (tick && (h_count == H_LAST)),
    .count   (v_count),
    .sync_on (v_sync),
    .active  (v_active),
    .pos     (v_pos)
  );

  assign at_origin = (h_count == '0) && (v_count == '0);
  assign vis       = h_active && v_active;
  // A selection arriving on the sampling tick itself governs the new frame.
  assign pat_now   = at_origin ? pattern_t'(pattern_sel) : pat_q;

  // Bar position tracked with a width counter so no divider is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (tick) begin
      if (!h_active) begin
        bar_cnt <= '0;
        bar_idx <= '0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rgb_next = 24'h000000;
    if (vis) begin
      case (pat_now)
        PAT_WHITE:   rgb_next = 24'hFFFFFF;
        PAT_BARS:    rgb_next = bar_colour(bar_idx);
        PAT_CHECKER: rgb_next = (h_pos[5] ^ v_pos[5]) ? 24'h000000 : 24'hFFFFFF;
        default:     rgb_next = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HSync       <= ~SYNC_POL;
      VSync       <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      {Red, Green, Blue} <= 24'h000000;
      pat_q       <= PAT_WHITE;
    end else begin
      frame_start <= tick && vis && (h_pos == '0) && (v_pos == '0);
      if (tick) begin
        HSync <= h_sync ? SYNC_POL : ~SYNC_POL;
        VSync <= v_sync ? SYNC_POL : ~SYNC_POL;
        de    <= vis;
        pix_x <= vis ? h_pos : '0;
        pix_y <= vis ? v_pos : '0;
        {Red, Green, Blue} <= rgb_next;
        if (at_origin)
          pat_q <= pat_now;
      end
    end
  end

endmodule
